// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle signed/unsigned multiply, multiply-accumulate and restoring divide
// returning a {HI,LO} result; stalls the pipeline while busy and can be annulled on flush.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               annul_i,
    input  logic [2:0]         op_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic [2*WIDTH-1:0] hilo_i,
    output logic               stall_o,
    output logic               ready_o,
    output logic [2*WIDTH-1:0] result_o,
    output logic               div_by_zero_o
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);
    state_t state;
    logic [1:0] acc_q;
    logic [WIDTH-1:0] a_q, b_q, rem_q;
    logic [2*WIDTH-1:0] hilo_q;
    logic neg_q, a_neg_q;
    logic [CNT_W-1:0] cnt_q;
    logic signed_op, accept;
    logic [WIDTH-1:0] a_abs, b_abs, rem_next, quot_f, rem_f;
    logic [2*WIDTH-1:0] prod_u, prod, mul_res;
    logic [WIDTH:0] r_shift;
    logic fits;
    assign signed_op = ~op_i[0];
    assign accept    = (state == IDLE) && start_i && !annul_i;
    assign stall_o   = accept || state == MUL || state == DIV;
    assign a_abs     = (signed_op && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign b_abs     = (signed_op && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    assign prod_u    = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    assign prod      = neg_q ? -prod_u : prod_u;
    assign mul_res   = acc_q == 2'd1 ? hilo_q + prod : acc_q == 2'd2 ? hilo_q - prod : prod;
    // a_q doubles as the dividend shift register; quotient bits enter at its LSB
    assign r_shift   = {rem_q, a_q[WIDTH-1]};
    assign fits      = r_shift >= {1'b0, b_q};
    assign rem_next  = fits ? r_shift[WIDTH-1:0] - b_q : r_shift[WIDTH-1:0];
    assign quot_f    = neg_q ? -a_q : a_q;
    assign rem_f     = a_neg_q ? -rem_q : rem_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            acc_q         <= '0;
            a_q           <= '0;
            b_q           <= '0;
            rem_q         <= '0;
            hilo_q        <= '0;
            neg_q         <= 1'b0;
            a_neg_q       <= 1'b0;
            cnt_q         <= '0;
            ready_o       <= 1'b0;
            result_o      <= '0;
            div_by_zero_o <= 1'b0;
        end else begin
            ready_o       <= 1'b0;
            div_by_zero_o <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    acc_q   <= op_i[2:1];
                    a_q     <= a_abs;
                    b_q     <= b_abs;
                    hilo_q  <= hilo_i;
                    neg_q   <= signed_op && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    a_neg_q <= signed_op && opdata1_i[WIDTH-1];
                    cnt_q   <= '0;
                    rem_q   <= '0;
                    if (op_i[2:1] == 2'd3 && opdata2_i == '0) begin
                        state         <= DONE;
                        result_o      <= {opdata1_i, {WIDTH{1'b1}}};
                        ready_o       <= 1'b1;
                        div_by_zero_o <= 1'b1;
                    end else begin
                        state <= op_i[2:1] == 2'd3 ? DIV : MUL;
                    end
                end
                MUL: if (annul_i) begin
                    state <= IDLE;
                end else begin
                    state    <= DONE;
                    result_o <= mul_res;
                    ready_o  <= 1'b1;
                end
                DIV: if (annul_i) begin
                    state <= IDLE;
                end else if (cnt_q == LAST) begin
                    state    <= DONE;
                    result_o <= {rem_f, quot_f};
                    ready_o  <= 1'b1;
                end else begin
                    rem_q <= rem_next;
                    a_q   <= {a_q[WIDTH-2:0], fits};
                    cnt_q <= cnt_q + 1'b1;
                end
                DONE: state <= IDLE;
            endcase
        end
    end
endmodule
